// File: rtl/pipelined_ling_adder.sv
// Pipelined Ling adder/subtractor: Ling carry blocks are spread across STAGES register stages.
// The whole pipeline advances together under a valid/ready handshake with a global stall.
module pipelined_ling_adder #(
  parameter int N      = 8,
  parameter int K      = 4,
  parameter int STAGES = 2
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         Ovf
);

  localparam int NB       = (N + K - 1) / K;
  localparam int SAFE_STG = (STAGES < 1) ? 1 : STAGES;
  localparam int BPS      = (NB + SAFE_STG - 1) / SAFE_STG;

  generate
    if (STAGES < 1 || STAGES > NB) begin : g_bad_stages
      $error("pipelined_ling_adder: STAGES must be in 1..NB");
    end
  endgenerate

  // carry is the carry into the next unresolved block (Cout once all blocks are done);
  // cmsb is the carry into bit N-1, kept for the overflow flag.
  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] bop;
    logic [N-1:0] sum;
    logic         carry;
    logic         cmsb;
  } bank_t;

  bank_t bank_q  [SAFE_STG+1];
  logic  valid_q [SAFE_STG+1];
  bank_t stage_d [SAFE_STG];
  bank_t in_d;
  logic  advance;

  logic c, cin_blk, h, hz, zc, cbit, g, p, p_prev, p_blk;

  assign advance  = ~valid_q[SAFE_STG] | out_ready;
  assign in_ready = ~reset & advance;

  always_comb begin
    in_d       = '0;
    in_d.a     = A;
    in_d.bop   = sub ? ~B : B;
    in_d.carry = sub ? ~Cin : Cin;
  end

  // Each stage walks its own bits; H is the Ling pseudo-carry, hz the same chain with carry-in 0.
  always_comb begin
    c       = 1'b0;
    cin_blk = 1'b0;
    h       = 1'b0;
    hz      = 1'b0;
    zc      = 1'b0;
    cbit    = 1'b0;
    g       = 1'b0;
    p       = 1'b0;
    p_prev  = 1'b0;
    p_blk   = 1'b0;
    for (int s = 0; s < SAFE_STG; s++) begin
      stage_d[s] = bank_q[s];
      c = bank_q[s].carry;
      for (int i = 0; i < N; i++) begin
        if ((i / K) >= s * BPS && (i / K) < (s + 1) * BPS) begin
          g = bank_q[s].a[i] & bank_q[s].bop[i];
          p = bank_q[s].a[i] | bank_q[s].bop[i];
          if (i % K == 0) begin
            cin_blk = c;
            h       = c;
            hz      = 1'b0;
            zc      = 1'b0;
            p_blk   = 1'b1;
            cbit    = c;
          end else begin
            cbit = p_prev & h;
            zc   = p_prev & hz;
          end
          stage_d[s].sum[i] = bank_q[s].a[i] ^ bank_q[s].bop[i] ^ cbit;
          if (i == N - 1) stage_d[s].cmsb = cbit;
          h      = g | cbit;
          hz     = g | zc;
          p_blk  = p_blk & p;
          p_prev = p;
          // Block carry = G_block | (P_block & block carry-in).
          if ((i % K == K - 1) || (i == N - 1)) c = (p & hz) | (p_blk & cin_blk);
        end
      end
      stage_d[s].carry = c;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int s = 0; s <= SAFE_STG; s++) begin
        valid_q[s] <= 1'b0;
        bank_q[s]  <= '0;
      end
    end else if (advance) begin
      valid_q[0] <= in_valid;
      if (in_valid) bank_q[0] <= in_d;
      for (int s = 0; s < SAFE_STG; s++) begin
        valid_q[s+1] <= valid_q[s];
        if (valid_q[s]) bank_q[s+1] <= stage_d[s];
      end
    end
  end

  assign out_valid = valid_q[SAFE_STG];
  assign S         = bank_q[SAFE_STG].sum;
  assign Cout      = bank_q[SAFE_STG].carry;
  assign Ovf       = bank_q[SAFE_STG].cmsb ^ bank_q[SAFE_STG].carry;

endmodule

// File: tb/tb_pipelined_ling_adder.sv
// Bench for pipelined_ling_adder: an 8-bit/2-stage and a 10-bit/3-stage instance checked
// against an arithmetic reference model with directed, streaming, reset and random traffic.
module tb_pipelined_ling_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, ir8, ov8, or8, cin8, sub8, co8, of8;
  logic [7:0] a8, b8, s8;
  logic       iv10, ir10, ov10, or10, cin10, sub10, co10, of10;
  logic [9:0] a10, b10, s10;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  pipelined_ling_adder #(.N(8), .K(4), .STAGES(2)) dut8 (
    .CLOCK_50(clk), .reset(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .Cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .S(s8), .Cout(co8), .Ovf(of8)
  );

  pipelined_ling_adder #(.N(10), .K(4), .STAGES(3)) dut10 (
    .CLOCK_50(clk), .reset(rst), .in_valid(iv10), .in_ready(ir10), .A(a10), .B(b10),
    .Cin(cin10), .sub(sub10), .out_valid(ov10), .out_ready(or10), .S(s10), .Cout(co10), .Ovf(of10)
  );

  // Reference: plain integer arithmetic; returns {Ovf, Cout, S[9:0]}.
  function automatic logic [11:0] refModel(input int n, input logic [9:0] a, input logic [9:0] b,
                                           input logic cin, input logic sb);
    longint m, ua, ub, ci, r, sa, sbv, sr;
    logic [11:0] res;
    m   = longint'(1) << n;
    ua  = longint'(a);
    ub  = longint'(b);
    ci  = cin ? 1 : 0;
    r   = sb ? (ua - ub - ci) : (ua + ub + ci);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    sr  = sb ? (sa - sbv - ci) : (sa + sbv + ci);
    res = '0;
    res[9:0] = 10'(((r % m) + m) % m);
    res[10]  = sb ? (r >= 0) : (r >= m);
    res[11]  = (sr < -(m / 2)) || (sr >= m / 2);
    return res;
  endfunction

  function automatic logic getOv(input int d);
    return (d != 0) ? ov10 : ov8;
  endfunction

  function automatic logic getIr(input int d);
    return (d != 0) ? ir10 : ir8;
  endfunction

  function automatic logic [11:0] getRes(input int d);
    return (d != 0) ? {of10, co10, s10} : {of8, co8, 2'b00, s8};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int d, input logic v, input logic [9:0] a, input logic [9:0] b,
                               input logic cin, input logic sb);
    if (d == 0) begin
      iv8 = v; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sb;
    end else begin
      iv10 = v; a10 = a; b10 = b; cin10 = cin; sub10 = sb;
    end
  endtask

  // One isolated word: checks acceptance, exact latency in cycles, and the result.
  task automatic sendOne(input int d, input string tag, input logic [9:0] a, input logic [9:0] b,
                         input logic cin, input logic sb, input int lat, input logic [9:0] es,
                         input logic eco, input logic eof);
    int k;
    @(negedge clk);
    applyStimulus(d, 1'b1, a, b, cin, sb);
    #1 checkOutput({tag, "_in_ready"}, 32'(getIr(d)), 32'd1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(d, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    k = 0;
    while (!getOv(d) && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_latency"}, 32'(k), 32'(lat));
    checkOutput({tag, "_result"}, 32'(getRes(d)), 32'({eof, eco, es}));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [9:0]  wa [16];
    logic [9:0]  wb [16];
    logic        wc [16];
    logic        ws [16];
    logic [11:0] wexp [16];
    logic [11:0] hold;
    logic [11:0] expq [$];
    logic [9:0]  ra, rb;
    logic        rc, rs, rv, seen;
    int          idx, del, sent, got, cyc;

    rst = 1'b1;
    or8 = 1'b1;
    or10 = 1'b1;
    hold = '0;
    applyStimulus(0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(ov8), 32'd0);
    checkOutput("reset_outputs", 32'(getRes(0)), 32'd0);
    checkOutput("reset_in_ready", 32'(ir8), 32'd0);
    checkOutput("reset_in_ready10", 32'(ir10), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("post_reset_in_ready", 32'(ir8), 32'd1);

    sendOne(0, "add_7f_01", 10'h07F, 10'h001, 1'b0, 1'b0, 2, 10'h080, 1'b0, 1'b1);
    sendOne(0, "sub_05_07", 10'h005, 10'h007, 1'b0, 1'b1, 2, 10'h0FE, 1'b0, 1'b0);
    sendOne(0, "sub_80_01", 10'h080, 10'h001, 1'b0, 1'b1, 2, 10'h07F, 1'b1, 1'b1);
    sendOne(0, "add_ff_cin", 10'h0FF, 10'h000, 1'b1, 1'b0, 2, 10'h000, 1'b1, 1'b0);
    sendOne(0, "add_0f_01", 10'h00F, 10'h001, 1'b0, 1'b0, 2, 10'h010, 1'b0, 1'b0);
    sendOne(0, "sub_00_bin", 10'h000, 10'h000, 1'b1, 1'b1, 2, 10'h0FF, 1'b0, 1'b0);
    sendOne(1, "n10_3ff_01", 10'h3FF, 10'h001, 1'b0, 1'b0, 3, 10'h000, 1'b1, 1'b0);

    // Random streaming on the 10-bit instance with random bubbles and backpressure.
    sent = 0; got = 0; cyc = 0;
    while (got < 200 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      ra = 10'($urandom); rb = 10'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      rv = (sent < 200) && ($urandom_range(0, 4) != 0);
      applyStimulus(1, rv, ra, rb, rc, rs);
      or10 = ($urandom_range(0, 3) != 0);
      #1;
      if (ov10 && or10) begin
        if (expq.size() == 0) checkOutput("rand_spurious", 32'(ov10), 32'd0);
        else checkOutput("rand_word", 32'(getRes(1)), 32'(expq.pop_front()));
        got++;
      end
      if (iv10 && ir10) begin
        expq.push_back(refModel(10, ra, rb, rc, rs));
        sent++;
      end
    end
    checkOutput("rand_count", 32'(got), 32'd200);
    @(negedge clk);
    applyStimulus(1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    or10 = 1'b1;
    repeat (5) @(negedge clk);

    // 16 back-to-back words with out_ready low in cycles 5..8.
    for (int i = 0; i < 16; i++) begin
      wa[i] = 10'($urandom_range(1, 255)); wb[i] = 10'($urandom_range(0, 255));
      wc[i] = 1'($urandom); ws[i] = 1'($urandom);
      wexp[i] = refModel(8, wa[i], wb[i], wc[i], ws[i]);
    end
    idx = 0; del = 0;
    for (int c = 0; c < 80 && del < 16; c++) begin
      @(negedge clk);
      or8 = !(c >= 5 && c <= 8);
      if (idx < 16) applyStimulus(0, 1'b1, wa[idx], wb[idx], wc[idx], ws[idx]);
      else applyStimulus(0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
      #1;
      if (c < 20) checkOutput("bp_in_ready", 32'(ir8), (c >= 5 && c <= 8) ? 32'd0 : 32'd1);
      if (c == 5) hold = getRes(0);
      if (c >= 6 && c <= 8) checkOutput("bp_hold", 32'({ov8, getRes(0)}), 32'({1'b1, hold}));
      if (ov8 && or8) begin
        checkOutput("bp_word", 32'(getRes(0)), 32'(wexp[del]));
        del++;
      end
      if (iv8 && ir8) idx++;
    end
    checkOutput("bp_count", 32'(del), 32'd16);
    @(negedge clk);
    applyStimulus(0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    or8 = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ov8) seen = 1'b1;
    end
    checkOutput("bp_no_duplicate", 32'(seen), 32'd0);

    // Reset with two words in flight.
    @(negedge clk);
    applyStimulus(0, 1'b1, 10'h03C, 10'h021, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(0, 1'b1, 10'h010, 10'h022, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1 checkOutput("rst_mid_in_ready", 32'(ir8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid", 32'(ov8), 32'd0);
    checkOutput("rst_mid_outputs", 32'(getRes(0)), 32'd0);
    checkOutput("rst_mid_in_ready_after", 32'(ir8), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ov8) seen = 1'b1;
    end
    checkOutput("rst_no_ghost", 32'(seen), 32'd0);
    sendOne(0, "post_rst_word", 10'h012, 10'h034, 1'b0, 1'b0, 2, 10'h046, 1'b0, 1'b0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
